dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the 2-stage CPU's data bus. It services the CPU's single-cycle read requests (`re`/`raddr`) with `rdata` exactly one cycle later, and absorbs single-cycle writes (`we`/`waddr`/`wdata`). It contains a word-addressed RAM region plus a small MMIO page: a 32-bit cycle counter, a GPIO output register and a 4-entry byte console FIFO with a ready/valid drain port. It sits between the CPU's data ports and the board-level I/O.

## Interface
- `DADDRWIDTH`, 16, data address width (word addresses).
- `DWIDTH`, 16, data word width.
- `RAM_WORDS`, 4096, RAM size; RAM occupies addresses 0 to RAM_WORDS-1.
- `MMIO_BASE`, 16'hFF00, base of the MMIO page (offsets 0-4 decoded, rest unmapped).
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `raddr`  in  DADDRWIDTH  read address, valid when `re`.
- `re`  in  1  read request, one cycle per read.
- `rdata`  out  DWIDTH  read data, registered.
- `waddr`  in  DADDRWIDTH  write address, valid when `we`.
- `wdata`  in  DWIDTH  write data.
- `we`  in  1  write strobe, one cycle per write.
- `gpio_out`  out  16  GPIO output register.
- `cons_data`  out  8  console FIFO head byte.
- `cons_valid`  out  1  FIFO not empty.
- `cons_ready`  in  1  consumer accepts head byte.

## Operation
- Address decode: RAM if address < RAM_WORDS; MMIO if MMIO_BASE+0..4; otherwise unmapped. Unmapped reads return 0; unmapped writes are ignored.
- MMIO map:
  - +0 CYCLE_LO (R/W): read returns counter[15:0] and snapshots counter[31:16] into the HI shadow. Any write clears the 32-bit counter.
  - +1 CYCLE_HI (R): returns the HI shadow. Writes are ignored.
  - +2 GPIO (R/W): drives `gpio_out`.
  - +3 CONS_DATA (W): pushes `wdata[7:0]`. Reads return 0.
  - +4 CONS_STATUS (R/W): bit0 empty, bit1 full, bit2 overflow (sticky), bits[6:4] count (0-4), other bits 0. A write with `wdata[2]`=1 clears overflow; other bits are ignored.
- Cycle counter: 32-bit, increments every cycle and wraps from FFFF_FFFF to 0.
- Console FIFO: depth 4, circular, with 2-bit read/write pointers and a 3-bit count.
  - A push is accepted when not full, or when full and a pop occurs in the same cycle.
  - A push to a full FIFO with no pop is dropped and sets overflow.
  - Pop occurs when `cons_valid && cons_ready`.
  - `cons_data` is the head entry. It is undefined-but-stable when empty; the bench must not check it then.
- Simultaneous read and write:
  - Same RAM address: write-first; `rdata` returns the new `wdata`.
  - Different addresses: both complete independently.
  - MMIO read and MMIO write in the same cycle: the read returns pre-write state (e.g. STATUS read alongside a CONS_DATA push shows the old count).
- `re` and `we` may be asserted in consecutive or the same cycles with no spacing requirement. There is no back-pressure to the CPU.

## Timing
- Read latency is exactly 1: `re` in cycle N gives `rdata` valid for all of cycle N+1. `rdata` holds its value until the next `re`; cycles without `re` leave it unchanged.
- Write takes effect at the end of the cycle in which `we` is high. A read issued in cycle N+1 sees the write.
- Counter clear: a CYCLE_LO write in cycle N makes the counter 0 during N+1 and 1 during N+2.
- A FIFO push in cycle N sets `cons_valid` in cycle N+1. A pop in cycle N advances `cons_data` in cycle N+1.
- Reset values (asynchronous, while `rst_n`=0):
  - `rdata`=0, `gpio_out`=0, counter=0, HI shadow=0.
  - FIFO empty, `cons_valid`=0, overflow=0.
- RAM contents are not reset and are preserved across reset.
- Reset asserted mid-operation aborts any pending read return (`rdata` forced to 0) and discards FIFO contents. The first read after release behaves normally.

## Test plan
- Write 16'hBEEF to RAM 0x0010, then `re` at 0x0010 in the next cycle → `rdata`=BEEF exactly one cycle after `re`, held through 3 idle cycles.
- Same-cycle `we` 0x0020←1234 and `re` 0x0020 → next cycle `rdata`=1234. `re` at 0x8000 (unmapped) → `rdata`=0.
- Write CYCLE_LO in cycle N, read CYCLE_LO in cycle N+5 → `rdata`=5. Preload counter near 0000_FFFF, read LO then HI → HI matches the snapshot, not the live value.
- Push 0x41..0x45 with `cons_ready`=0:
  - After the fifth push, STATUS=0x0046 (count 4, full, overflow).
  - Raise `cons_ready` → bytes drain in order 41,42,43,44, then `cons_valid`=0.
  - Write STATUS with bit2 set → STATUS=0x0001.
- With the FIFO full and `cons_ready`=1, push 0x50 in the same cycle → push accepted, count stays 4, overflow stays 0, 0x50 drains last.
- Write GPIO=0x00A5 and fill FIFO with 2 bytes, then pulse `rst_n` low mid-cycle → `gpio_out`=0, `cons_valid`=0 and `rdata`=0 immediately. RAM word written before reset still reads back unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus an MMIO page with a cycle counter,
// GPIO register and a 4-deep byte console FIFO. Reads return one cycle later.
module dmem_responder #(
   parameter int                      DADDRWIDTH = 16,
   parameter int                      DWIDTH     = 16,
   parameter int                      RAM_WORDS  = 4096,
   parameter logic [DADDRWIDTH-1:0]   MMIO_BASE  = 16'hFF00
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DADDRWIDTH-1:0] raddr,
   input  logic                  re,
   output logic [DWIDTH-1:0]     rdata,
   input  logic [DADDRWIDTH-1:0] waddr,
   input  logic [DWIDTH-1:0]     wdata,
   input  logic                  we,
   output logic [15:0]           gpio_out,
   output logic [7:0]            cons_data,
   output logic                  cons_valid,
   input  logic                  cons_ready
);

   localparam int AW = $clog2(RAM_WORDS);
   localparam logic [DADDRWIDTH-1:0] OFF_CLO   = DADDRWIDTH'(0);
   localparam logic [DADDRWIDTH-1:0] OFF_CHI   = DADDRWIDTH'(1);
   localparam logic [DADDRWIDTH-1:0] OFF_GPIO  = DADDRWIDTH'(2);
   localparam logic [DADDRWIDTH-1:0] OFF_CDATA = DADDRWIDTH'(3);
   localparam logic [DADDRWIDTH-1:0] OFF_CSTAT = DADDRWIDTH'(4);

   logic                  r_ram, r_mmio, w_ram, w_mmio;
   logic [DADDRWIDTH-1:0] roff, woff;

   assign r_ram  = 32'(raddr) < RAM_WORDS;
   assign w_ram  = 32'(waddr) < RAM_WORDS;
   assign roff   = raddr - MMIO_BASE;
   assign woff   = waddr - MMIO_BASE;
   assign r_mmio = (raddr >= MMIO_BASE) && (roff <= OFF_CSTAT);
   assign w_mmio = (waddr >= MMIO_BASE) && (woff <= OFF_CSTAT);

   logic wr_clo, wr_gpio, wr_cdata, wr_cstat;
   assign wr_clo   = we && w_mmio && (woff == OFF_CLO);
   assign wr_gpio  = we && w_mmio && (woff == OFF_GPIO);
   assign wr_cdata = we && w_mmio && (woff == OFF_CDATA);
   assign wr_cstat = we && w_mmio && (woff == OFF_CSTAT);

   // RAM contents survive reset, so this array has no reset branch.
   logic [DWIDTH-1:0] mem [RAM_WORDS];
   always_ff @(posedge clk) begin
      if (we && w_ram) mem[waddr[AW-1:0]] <= wdata;
   end

   logic [DWIDTH-1:0] rdata_q, rdata_d;
   logic [31:0]       cnt_q, cnt_d, cnt_inc;
   logic [15:0]       hi_q, hi_d;
   logic [15:0]       gpio_q, gpio_d;

   logic [7:0] fifo_q [4];
   logic [7:0] fifo_d [4];
   logic [1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [2:0] count_q, count_d;
   logic       ovf_q, ovf_d;
   logic       empty, full, pop, push;
   logic [6:0] status;

   assign empty  = (count_q == 3'd0);
   assign full   = (count_q == 3'd4);
   assign pop    = !empty && cons_ready;
   assign push   = wr_cdata && (!full || pop);
   assign status = {count_q, 1'b0, ovf_q, full, empty};

   // The counter read reports the value the counter holds while rdata is
   // presented, and ignores a same-cycle clear (reads see pre-write state).
   assign cnt_inc = cnt_q + 32'd1;

   always_comb begin
      cnt_d  = wr_clo ? 32'd0 : cnt_inc;
      gpio_d = wr_gpio ? wdata[15:0] : gpio_q;
   end

   always_comb begin
      rdata_d = rdata_q;
      hi_d    = hi_q;
      if (re) begin
         rdata_d = '0;
         if (r_ram) begin
            rdata_d = (we && w_ram && (waddr == raddr)) ? wdata : mem[raddr[AW-1:0]];
         end else if (r_mmio) begin
            case (roff)
               OFF_CLO: begin
                  rdata_d = DWIDTH'(cnt_inc[15:0]);
                  hi_d    = cnt_inc[31:16];
               end
               OFF_CHI:   rdata_d = DWIDTH'(hi_q);
               OFF_GPIO:  rdata_d = DWIDTH'(gpio_q);
               OFF_CSTAT: rdata_d = DWIDTH'(status);
               default:   rdata_d = '0;
            endcase
         end
      end
   end

   always_comb begin
      fifo_d  = fifo_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (push) begin
         fifo_d[wptr_q] = wdata[7:0];
         wptr_d         = wptr_q + 2'd1;
      end
      if (pop) rptr_d = rptr_q + 2'd1;
      case ({push, pop})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase
      if (wr_cdata && full && !pop) ovf_d = 1'b1;
      else if (wr_cstat && wdata[2]) ovf_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         gpio_q  <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      end else begin
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         gpio_q  <= gpio_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         fifo_q  <= fifo_d;
      end
   end

   assign rdata      = rdata_q;
   assign gpio_out   = gpio_q;
   assign cons_data  = fifo_q[rptr_q];
   assign cons_valid = !empty;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected read data and console bytes
// are queued at issue time and checked by an independent monitor.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] raddr, waddr, wdata;
   logic        re, we, cons_ready;
   logic [15:0] rdata, gpio_out;
   logic [7:0]  cons_data;
   logic        cons_valid;

   always #5 clk = ~clk;

   dmem_responder dut (
      .clk(clk), .rst_n(rst_n),
      .raddr(raddr), .re(re), .rdata(rdata),
      .waddr(waddr), .wdata(wdata), .we(we),
      .gpio_out(gpio_out),
      .cons_data(cons_data), .cons_valid(cons_valid), .cons_ready(cons_ready)
   );

   int          n_chk = 0;
   int          n_err = 0;
   logic [15:0] exp_rd[$];
   logic [7:0]  exp_cons[$];
   logic [15:0] last_exp = 16'h0;
   logic        rd_pend = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) rd_pend = re && rst_n;

   // Monitor: rdata one cycle after each re, held otherwise; bytes on each pop.
   always @(negedge clk) begin
      logic [7:0] eb;
      if (!rst_n) begin
         exp_rd.delete();
         exp_cons.delete();
         last_exp = 16'h0;
      end else begin
         if (rd_pend) begin
            chk("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
            if (exp_rd.size() != 0) begin
               last_exp = exp_rd.pop_front();
               chk("rdata", 32'(rdata), 32'(last_exp));
            end
         end else begin
            chk("rdata_hold", 32'(rdata), 32'(last_exp));
         end
         if (cons_valid && cons_ready) begin
            chk("cons_expected", 32'(exp_cons.size() != 0), 32'd1);
            if (exp_cons.size() != 0) begin
               eb = exp_cons.pop_front();
               chk("cons_data", 32'(cons_data), 32'(eb));
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      we = 1'b1; waddr = a; wdata = d;
      cyc();
      we = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, input logic [15:0] e);
      re = 1'b1; raddr = a;
      exp_rd.push_back(e);
      cyc();
      re = 1'b0;
   endtask

   task automatic rdwr(input logic [15:0] wa, input logic [15:0] wd,
                       input logic [15:0] ra, input logic [15:0] e);
      we = 1'b1; waddr = wa; wdata = wd;
      re = 1'b1; raddr = ra;
      exp_rd.push_back(e);
      cyc();
      we = 1'b0; re = 1'b0;
   endtask

   task automatic push(input logic [7:0] b, input bit accepted);
      if (accepted) exp_cons.push_back(b);
      wr(16'hFF03, {8'h00, b});
   endtask

   initial begin
      re = 1'b0; we = 1'b0; raddr = '0; waddr = '0; wdata = '0; cons_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rdata", 32'(rdata), 32'h0);
      chk("reset_gpio", 32'(gpio_out), 32'h0);
      chk("reset_cons_valid", 32'(cons_valid), 32'h0);
      rst_n = 1'b1;
      cyc();

      // RAM write then read, held while idle
      wr(16'h0010, 16'hBEEF);
      rd(16'h0010, 16'hBEEF);
      repeat (3) cyc();
      chk("beef_hold", 32'(rdata), 32'h0000BEEF);

      // write-first, independent addresses, unmapped space
      rdwr(16'h0020, 16'h1234, 16'h0020, 16'h1234);
      rdwr(16'h0021, 16'hAAAA, 16'h0010, 16'hBEEF);
      rd(16'h0021, 16'hAAAA);
      rd(16'h8000, 16'h0000);
      wr(16'h9000, 16'h5555);
      rd(16'h9000, 16'h0000);

      // cycle counter: clear, read five cycles later
      wr(16'hFF00, 16'h0000);
      repeat (4) cyc();
      rd(16'hFF00, 16'h0005);

      // HI shadow across the 16-bit boundary
      wr(16'hFF00, 16'h0000);
      repeat (65534) cyc();
      rd(16'hFF00, 16'hFFFF);
      rd(16'hFF01, 16'h0000);
      rd(16'hFF00, 16'h0001);
      rd(16'hFF01, 16'h0001);

      // GPIO
      wr(16'hFF02, 16'h00A5);
      chk("gpio_out", 32'(gpio_out), 32'h00A5);
      rd(16'hFF02, 16'h00A5);

      // console FIFO fill, overflow, drain, clear
      cons_ready = 1'b0;
      exp_cons.push_back(8'h41);
      rdwr(16'hFF03, 16'h0041, 16'hFF04, 16'h0001);
      push(8'h42, 1'b1);
      push(8'h43, 1'b1);
      push(8'h44, 1'b1);
      push(8'h45, 1'b0);
      rd(16'hFF04, 16'h0046);
      rd(16'hFF03, 16'h0000);
      cons_ready = 1'b1;
      repeat (6) cyc();
      chk("drain_valid", 32'(cons_valid), 32'h0);
      chk("drain_left", 32'(exp_cons.size()), 32'h0);
      cons_ready = 1'b0;
      rd(16'hFF04, 16'h0005);
      wr(16'hFF04, 16'h0004);
      rd(16'hFF04, 16'h0001);

      // push into a full FIFO while it pops
      push(8'h51, 1'b1);
      push(8'h52, 1'b1);
      push(8'h53, 1'b1);
      push(8'h54, 1'b1);
      cons_ready = 1'b1;
      push(8'h50, 1'b1);
      cons_ready = 1'b0;
      rd(16'hFF04, 16'h0042);
      cons_ready = 1'b1;
      repeat (6) cyc();
      chk("drain2_valid", 32'(cons_valid), 32'h0);
      chk("drain2_left", 32'(exp_cons.size()), 32'h0);
      cons_ready = 1'b0;
      rd(16'hFF04, 16'h0001);

      // asynchronous reset mid-operation
      wr(16'hFF02, 16'h00A5);
      push(8'h70, 1'b1);
      push(8'h71, 1'b1);
      wr(16'h0030, 16'hCAFE);
      rd(16'h0030, 16'hCAFE);
      cyc();
      chk("pre_reset_valid", 32'(cons_valid), 32'h1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_gpio", 32'(gpio_out), 32'h0);
      chk("rst_cons_valid", 32'(cons_valid), 32'h0);
      chk("rst_rdata", 32'(rdata), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      rd(16'h0030, 16'hCAFE);
      rd(16'h0010, 16'hBEEF);
      rd(16'hFF04, 16'h0001);
      repeat (2) cyc();
      chk("rd_all_seen", 32'(exp_rd.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
